led_status_ctrl: RTL and testbench

Parametrised board-status indicator engine for the BSODomizer HD top level. It replaces the single fixed heartbeat bit with NUM_CH independently moded LED channels (off / on / blink / event-stretch), a global PWM brightness, a dedicated heartbeat and a shared millisecond tick. It runs in the 50 MHz board clock domain and drives LEDG/LEDR directly from the top-level wrapper.

---
 rtl/led_status_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_led_status_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: board-status indicator engine.
// Provides NUM_CH independently moded LED channels (off / on / blink /
// event-stretch), global PWM brightness, a free-running heartbeat and a
// shared tick strobe, all in the CLOCK_50_B5B domain.
//
// Ports:
//   CLOCK_50_B5B  in   clock
//   reset_n       in   synchronous active-low reset
//   mode          in   [2*NUM_CH]  per-channel mode, [2i+1:2i]:
//                      00 off, 01 on, 10 blink, 11 event-stretch
//   blink_half    in   [16]  blink half-period in ticks (0 behaves as 1)
//   evt           in   [NUM_CH]  per-channel event inputs (synchronous)
//   bright        in   [PWM_BITS]  brightness, 0 dark, all-ones full on
//   led           out  [NUM_CH]  registered LED drive, active-high
//   heartbeat     out  registered square wave, 2*HB_HALF_TICKS ticks period
//   tick          out  registered one-cycle strobe every DIV clocks
module led_status_ctrl #(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned TICK_HZ       = 1000,
  parameter int unsigned HB_HALF_TICKS = 500,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter int unsigned PWM_BITS      = 4
) (
  input  logic                  CLOCK_50_B5B,
  input  logic                  reset_n,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [15:0]           blink_half,
  input  logic [NUM_CH-1:0]     evt,
  input  logic [PWM_BITS-1:0]   bright,
  output logic [NUM_CH-1:0]     led,
  output logic                  heartbeat,
  output logic                  tick
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BLK_W = 16;
  localparam int unsigned HB_W  = $clog2(HB_HALF_TICKS + 1);
  localparam int unsigned STR_W = $clog2(STRETCH_TICKS + 1);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_STRETCH = 2'b11;

  logic [PRE_W-1:0]    presc;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_phase;
  logic [HB_W-1:0]     hb_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_CH-1:0]   evt_q;

  logic                tick_c;
  logic [BLK_W-1:0]    blink_last_c;
  logic                blink_wrap_c;
  logic                hb_wrap_c;
  logic [NUM_CH-1:0]   rise_c;
  logic [NUM_CH-1:0]   stretch_on_c;
  logic [NUM_CH-1:0]   raw_c;
  logic                pwm_on_c;

  // Internal tick: the cycle in which the prescaler sits at its terminal count.
  assign tick_c = (presc == PRE_W'(DIV - 1));

  // Last blink count before wrap; a zero half-period behaves as one tick.
  always_comb begin
    blink_last_c = '0;
    if (blink_half != '0) begin
      blink_last_c = blink_half - BLK_W'(1);
    end
  end

  // ">=" lets a shortened half-period take effect on the very next tick.
  assign blink_wrap_c = (blink_cnt >= blink_last_c);
  assign hb_wrap_c    = (hb_cnt >= HB_W'(HB_HALF_TICKS - 1));

  // Rising edges only, so a held event produces a single stretch.
  assign rise_c = evt & ~evt_q;

  // Full scale is forced on; otherwise bright/2^PWM_BITS duty cycle.
  assign pwm_on_c = (&bright) | (pwm_cnt < bright);

  // Prescaler and registered tick strobe.
  always_ff @(posedge CLOCK_50_B5B) begin
    if (!reset_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= tick_c ? '0 : presc + PRE_W'(1);
      tick  <= tick_c;
    end
  end

  // Shared blink phase generator; every blinking channel uses this phase.
  always_ff @(posedge CLOCK_50_B5B) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick_c) begin
      if (blink_wrap_c) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  // Heartbeat: fixed half-period, independent of mode and brightness.
  always_ff @(posedge CLOCK_50_B5B) begin
    if (!reset_n) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (tick_c) begin
      if (hb_wrap_c) begin
        hb_cnt    <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        hb_cnt <= hb_cnt + HB_W'(1);
      end
    end
  end

  // Free-running PWM phase counter.
  always_ff @(posedge CLOCK_50_B5B) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Event history for edge detection; cleared in reset so an event
  // already high at release is seen as a fresh edge.
  always_ff @(posedge CLOCK_50_B5B) begin
    if (!reset_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt;
    end
  end

  // Per-channel stretch counter and raw state selection.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [STR_W-1:0] str_cnt;
    logic [1:0]       ch_mode_c;

    // Reload on an edge (even mid-stretch), else count down on ticks.
    always_ff @(posedge CLOCK_50_B5B) begin
      if (!reset_n) begin
        str_cnt <= '0;
      end else if (rise_c[g]) begin
        str_cnt <= STR_W'(STRETCH_TICKS);
      end else if (tick_c && (str_cnt != '0)) begin
        str_cnt <= str_cnt - STR_W'(1);
      end
    end

    assign stretch_on_c[g] = (str_cnt != '0);
    assign ch_mode_c       = mode[2*g +: 2];

    // Raw channel state before brightness gating.
    always_comb begin
      raw_c[g] = 1'b0;
      case (ch_mode_c)
        MODE_OFF:     raw_c[g] = 1'b0;
        MODE_ON:      raw_c[g] = 1'b1;
        MODE_BLINK:   raw_c[g] = blink_phase;
        MODE_STRETCH: raw_c[g] = stretch_on_c[g];
        default:      raw_c[g] = 1'b0;
      endcase
    end
  end

  // Output register: raw state gated by the shared PWM enable.
  always_ff @(posedge CLOCK_50_B5B) begin
    if (!reset_n) begin
      led <= '0;
    end else begin
      led <= raw_c & {NUM_CH{pwm_on_c}};
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Testbench for led_status_ctrl: directed stimulus, a tick-level reference
// model compared every cycle, and hand-computed literal expectations.
module tb_led_status_ctrl;

  localparam int NCH = 8;
  localparam int DIV = 10;
  localparam int HB  = 2;
  localparam int ST  = 4;
  localparam int PB  = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2*NCH-1:0] mode;
  logic [15:0]      blink_half;
  logic [NCH-1:0]   evt;
  logic [PB-1:0]    bright;
  logic [NCH-1:0]   led;
  logic             heartbeat;
  logic             tick;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .NUM_CH(NCH), .CLK_HZ(1000), .TICK_HZ(100),
    .HB_HALF_TICKS(HB), .STRETCH_TICKS(ST), .PWM_BITS(PB)
  ) dut (
    .CLOCK_50_B5B(clk),
    .reset_n(reset_n),
    .mode(mode),
    .blink_half(blink_half),
    .evt(evt),
    .bright(bright),
    .led(led),
    .heartbeat(heartbeat),
    .tick(tick)
  );

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: edges counted since reset release, ticks on every
  // DIV-th edge, stretches as an absolute end edge, blink as ticks elapsed
  // since the last toggle.
  int             t;
  int             s_end [NCH];
  int             b_last;
  logic           b_ph;
  logic [NCH-1:0] prev_ev;
  logic [NCH-1:0] e_led;
  logic           e_hb;
  logic           e_tick;
  logic           model_valid = 1'b0;
  int             nt;
  int             eff;
  logic           on_m;
  logic           raw_m;

  always @(posedge clk) begin
    if (!reset_n) begin
      t       = 0;
      b_last  = 0;
      b_ph    = 1'b0;
      prev_ev = '0;
      for (int i = 0; i < NCH; i++) s_end[i] = 0;
      e_led   = '0;
      e_hb    = 1'b0;
      e_tick  = 1'b0;
    end else begin
      t++;
      // led after edge t reflects state held after edge t-1
      on_m = (bright == '1) || (((t - 1) % 8) < int'(bright));
      for (int i = 0; i < NCH; i++) begin
        case (mode[2*i +: 2])
          2'b00:   raw_m = 1'b0;
          2'b01:   raw_m = 1'b1;
          2'b10:   raw_m = b_ph;
          default: raw_m = ((t - 1) < s_end[i]);
        endcase
        e_led[i] = raw_m & on_m;
      end
      for (int i = 0; i < NCH; i++) begin
        if (evt[i] && !prev_ev[i]) s_end[i] = ((t / DIV) + 1) * DIV + (ST - 1) * DIV;
      end
      prev_ev = evt;
      if (t % DIV == 0) begin
        nt  = t / DIV;
        eff = (blink_half == 16'd0) ? 1 : int'(blink_half);
        if (nt - b_last >= eff) begin
          b_ph   = ~b_ph;
          b_last = nt;
        end
      end
      e_tick = (t % DIV == 0);
      e_hb   = (((t / DIV) / HB) % 2) == 1;
    end
    model_valid = 1'b1;
  end

  // Per-cycle compare, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (model_valid) begin
      chk("led", int'(led), int'(e_led));
      chk("heartbeat", int'(heartbeat), int'(e_hb));
      chk("tick", int'(tick), int'(e_tick));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Negedges until led[ch] equals lvl; -1 if the bound expires.
  task automatic until_led(input int ch, input logic lvl, input int lim, output int j);
    j = -1;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (led[ch] == lvl) begin
        j = k;
        break;
      end
    end
  endtask

  task automatic pulse(input int ch);
    evt[ch] = 1'b1;
    @(negedge clk);
    evt[ch] = 1'b0;
  endtask

  int j;
  int first_t;
  int second_t;
  int cnt;
  logic hb0;

  initial begin
    reset_n    = 1'b0;
    mode       = '0;
    blink_half = 16'd3;
    evt        = '1;
    bright     = '1;
    cyc(5);
    chk("reset led", int'(led), 0);
    chk("reset heartbeat", int'(heartbeat), 0);
    chk("reset tick", int'(tick), 0);

    // Tick cadence after release
    evt     = '0;
    reset_n = 1'b1;
    first_t = -1; second_t = -1; cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (tick) begin
        cnt++;
        if (first_t < 0) first_t = k;
        else if (second_t < 0) second_t = k;
      end
    end
    chk("first tick", first_t, 10);
    chk("second tick", second_t, 20);
    chk("tick high cycles", cnt, 2);

    // Blink: ch0 blink, ch1 on
    mode = 16'h0006;
    cyc(2);
    chk("ch1 on", int'(led[1]), 1);
    until_led(0, ~led[0], 40, j);
    chk("blink sync3", int'(j > 0), 1);
    until_led(0, ~led[0], 40, j);
    chk("blink half3 period", j, 30);
    blink_half = 16'd0;
    until_led(0, ~led[0], 40, j);
    chk("blink sync0", int'(j > 0), 1);
    until_led(0, ~led[0], 40, j);
    chk("blink half0 period", j, 10);
    blink_half = 16'd5;
    until_led(0, ~led[0], 70, j);
    chk("blink sync5", int'(j > 0), 1);
    cyc(25);
    blink_half = 16'd1;
    until_led(0, ~led[0], 40, j);
    chk("blink shrink wrap", j, 5);

    // Event stretch on ch2
    blink_half = 16'd3;
    mode = 16'h0036;
    cyc(50);
    pulse(2);
    until_led(2, 1'b1, 5, j);
    chk("stretch rise delay", j, 1);
    until_led(2, 1'b0, 60, j);
    chk("stretch length in 31..40", int'(j >= 31 && j <= 40), 1);
    cyc(5);
    pulse(2);
    cyc(20);
    chk("stretch before retrigger", int'(led[2]), 1);
    pulse(2);
    until_led(2, 1'b0, 60, j);
    chk("retrigger tail in 32..41", int'(j >= 32 && j <= 41), 1);
    cyc(3);
    evt[2] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (led[2]) cnt++;
    end
    chk("held event one stretch", int'(cnt >= 31 && cnt <= 40), 1);
    chk("held event ends low", int'(led[2]), 0);
    evt[2] = 1'b0;
    cyc(20);

    // PWM on ch3
    mode = 16'h0040;
    bright = 3'd4;
    cyc(2);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (led[3]) cnt++;
    end
    chk("pwm bright4", cnt, 4);
    bright = 3'd0;
    cyc(2);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (led[3]) cnt++;
    end
    chk("pwm bright0", cnt, 0);
    bright = 3'd7;
    cyc(2);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (led[3]) cnt++;
    end
    chk("pwm bright7", cnt, 16);

    // Heartbeat with LEDs dark
    bright = 3'd0;
    hb0 = heartbeat;
    j = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (heartbeat != hb0) begin j = k; break; end
    end
    chk("hb sync", int'(j > 0), 1);
    hb0 = heartbeat;
    j = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (heartbeat != hb0) begin j = k; break; end
    end
    chk("hb half period", j, 20);

    // Reset during active stretch and blink-high
    bright = 3'd7;
    blink_half = 16'd1;
    mode = 16'h0032;
    pulse(2);
    until_led(0, 1'b1, 25, j);
    chk("pre-reset blink high", int'(j > 0), 1);
    chk("pre-reset stretch high", int'(led[2]), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset led", int'(led), 0);
    chk("midreset heartbeat", int'(heartbeat), 0);
    chk("midreset tick", int'(tick), 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(60);
    chk("stretch discarded", int'(led[2]), 0);
    reset_n = 1'b0;
    evt[2] = 1'b1;
    cyc(3);
    reset_n = 1'b1;
    until_led(2, 1'b1, 5, j);
    chk("re-edge after reset", j, 2);
    evt[2] = 1'b0;
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
